// File: rtl/clk_div_pkg.sv
// Shared definitions for divided-clock consumers: monitor FSM states and
// the duty-cycle tolerance helpers also used by the divider's assertions.
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } mon_state_e;

    function automatic int unsigned half_lo(input int unsigned div);
        return div / 2;
    endfunction

    function automatic int unsigned half_hi(input int unsigned div);
        return (div + 1) / 2;
    endfunction

endpackage

// File: rtl/clk_edge_det.sv
// Two-flop sampler for a clk_in-synchronous divided clock; flags rising and
// falling edges one cycle after the input changes.
module clk_edge_det (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sig_i,
    output logic rise_o,
    output logic fall_o,
    output logic level_o
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= sig_i;
            s2_q <= s1_q;
        end
    end

    assign rise_o  = s1_q & ~s2_q;
    assign fall_o  = ~s1_q & s2_q;
    assign level_o = s1_q;

endmodule

// File: rtl/clk_div_mon.sv
// Divided-clock monitor: measures period and high time of each div_clk_i
// cycle, qualifies lock after LOCK_CNT good periods, and flags a stuck clock.
module clk_div_mon
    import clk_div_pkg::*;
#(
    parameter int unsigned EXP_DIV  = 3,
    parameter int unsigned CW       = 8,
    parameter int unsigned LOCK_CNT = 4
) (
    input  logic          clk_in,
    input  logic          rst_n,
    input  logic          div_clk_i,
    output logic          meas_vld,
    output logic [CW-1:0] meas_period,
    output logic [CW-1:0] meas_high,
    output logic          lock,
    output logic          err,
    output logic          stuck
);

    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] EXP_P   = CW'(EXP_DIV);
    localparam logic [CW-1:0] HALF_LO = CW'(half_lo(EXP_DIV));
    localparam logic [CW-1:0] HALF_HI = CW'(half_hi(EXP_DIV));
    localparam logic [3:0]    LOCK_C  = 4'(LOCK_CNT);

    logic rise;
    logic fall;
    logic level;

    clk_edge_det u_edge (
        .clk_i  (clk_in),
        .rst_ni (rst_n),
        .sig_i  (div_clk_i),
        .rise_o (rise),
        .fall_o (fall),
        .level_o(level)
    );

    mon_state_e    state_q;
    logic [CW-1:0] hcnt_q;
    logic [CW-1:0] lcnt_q;
    logic [3:0]    run_q;

    logic [CW:0]   sum;
    logic [CW-1:0] period_d;
    logic [3:0]    run_d;
    logic          good;

    always_comb begin
        sum      = {1'b0, hcnt_q} + {1'b0, lcnt_q};
        period_d = sum[CW] ? CNT_MAX : sum[CW-1:0];
        good     = (period_d == EXP_P) && (hcnt_q == HALF_LO || hcnt_q == HALF_HI);
        run_d    = (run_q >= LOCK_C) ? LOCK_C : run_q + 4'd1;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hcnt_q      <= '0;
            lcnt_q      <= '0;
            run_q       <= '0;
            meas_vld    <= 1'b0;
            meas_period <= '0;
            meas_high   <= '0;
            lock        <= 1'b0;
            err         <= 1'b0;
            stuck       <= 1'b0;
        end else begin
            meas_vld <= 1'b0;
            err      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_q <= HIGH;
                        hcnt_q  <= CNT_ONE;
                        stuck   <= 1'b0;
                    end
                end
                HIGH: begin
                    // Saturation wins over a coincident edge: the period is abandoned.
                    if (hcnt_q == CNT_MAX) begin
                        state_q <= IDLE;
                        stuck   <= 1'b1;
                        lock    <= 1'b0;
                        run_q   <= '0;
                    end else if (fall) begin
                        state_q <= LOW;
                        lcnt_q  <= CNT_ONE;
                    end else if (level) begin
                        hcnt_q <= hcnt_q + CNT_ONE;
                    end
                end
                LOW: begin
                    if (lcnt_q == CNT_MAX) begin
                        state_q <= IDLE;
                        stuck   <= 1'b1;
                        lock    <= 1'b0;
                        run_q   <= '0;
                    end else if (rise) begin
                        state_q     <= HIGH;
                        hcnt_q      <= CNT_ONE;
                        stuck       <= 1'b0;
                        meas_vld    <= 1'b1;
                        meas_period <= period_d;
                        meas_high   <= hcnt_q;
                        if (good) begin
                            run_q <= run_d;
                            lock  <= (run_d == LOCK_C);
                        end else begin
                            run_q <= '0;
                            lock  <= 1'b0;
                            err   <= 1'b1;
                        end
                    end else if (!level) begin
                        lcnt_q <= lcnt_q + CNT_ONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
